sprite_desc_table: RTL and testbench

SPRITE_DESC_TABLE -- requirements
Module: sprite_desc_table

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_addr_calc.sv | 26 ++
 rtl/sprite_desc_table.sv | 138 +++++++++++++
 tb/tb_sprite_desc_table.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and descriptor layout for the sprite descriptor table.
// Descriptor fields are sized by these defaults; instances are expected to use them.
package sprite_pkg;

    localparam int SPR_ID_W   = 6;
    localparam int SPR_ADDR_W = 25;
    localparam int SPR_DIM_W  = 10;

    typedef struct packed {
        logic [SPR_ADDR_W-1:0] base;
        logic [SPR_DIM_W-1:0]  width;
        logic [SPR_DIM_W-1:0]  height;
    } sprite_desc_t;

endpackage

// File: rtl/sprite_addr_calc.sv
// Stage-2 arithmetic: bounds check of (x, y) against the sprite size and the
// linear pixel address base + y*width + x, wrapping at ADDR_W bits.
module sprite_addr_calc
    import sprite_pkg::*;
#(
    parameter int ADDR_W = SPR_ADDR_W,
    parameter int DIM_W  = SPR_DIM_W
) (
    input  logic              entry_valid,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  x,
    input  logic [DIM_W-1:0]  y,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] offset;

    always_comb begin
        hit    = entry_valid && (x < width) && (y < height);
        offset = ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
        addr   = hit ? (base + offset) : '0;
    end

endmodule

// File: rtl/sprite_desc_table.sv
// Sprite descriptor table with a 2-stage lookup pipeline: (id, x, y) in,
// pixel-memory address plus hit flag out, with a saturating miss counter.
module sprite_desc_table
    import sprite_pkg::*;
#(
    parameter int ID_W   = SPR_ID_W,
    parameter int ADDR_W = SPR_ADDR_W,
    parameter int DIM_W  = SPR_DIM_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ID_W-1:0]   wr_id,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [DIM_W-1:0]  wr_width,
    input  logic [DIM_W-1:0]  wr_height,
    input  logic              rq_valid,
    output logic              rq_ready,
    input  logic [ID_W-1:0]   rq_id,
    input  logic [DIM_W-1:0]  rq_x,
    input  logic [DIM_W-1:0]  rq_y,
    output logic              rs_valid,
    input  logic              rs_ready,
    output logic [ADDR_W-1:0] rs_addr,
    output logic              rs_hit,
    output logic [ID_W-1:0]   rs_id,
    output logic [15:0]       miss_cnt
);
    localparam int DEPTH = 2 ** ID_W;

    sprite_desc_t      desc_mem [DEPTH];
    sprite_desc_t      wr_desc;
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  valid_next;

    sprite_desc_t      s1_desc_reg;
    logic [DIM_W-1:0]  s1_x_reg;
    logic [DIM_W-1:0]  s1_y_reg;
    logic [ID_W-1:0]   s1_id_reg;
    logic              s1_valid_reg;
    logic              s1_entry_valid_reg;

    logic              rs_valid_reg;
    logic              rs_hit_reg;
    logic [ADDR_W-1:0] rs_addr_reg;
    logic [ID_W-1:0]   rs_id_reg;
    logic [15:0]       miss_cnt_reg;

    logic              stall;
    logic              accept;
    logic              calc_hit;
    logic [ADDR_W-1:0] calc_addr;

    // A held response freezes both stages together.
    assign stall    = rs_valid_reg && !rs_ready;
    assign accept   = rq_valid && !stall;
    assign rq_ready = !stall;

    always_comb begin
        wr_desc        = '0;
        wr_desc.base   = SPR_ADDR_W'(wr_base);
        wr_desc.width  = SPR_DIM_W'(wr_width);
        wr_desc.height = SPR_DIM_W'(wr_height);
    end

    // Registered RAM read; non-blocking semantics give read-before-write.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            desc_mem[wr_id] <= wr_desc;
        end
        if (accept) begin
            s1_desc_reg <= desc_mem[rq_id];
            s1_x_reg    <= rq_x;
            s1_y_reg    <= rq_y;
            s1_id_reg   <= rq_id;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_next[gi] = clr ? 1'b0 :
                                    ((wr_en && (wr_id == ID_W'(gi))) ? 1'b1 : valid_reg[gi]);
        end
    endgenerate

    sprite_addr_calc #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_calc (
        .entry_valid (s1_entry_valid_reg),
        .base        (ADDR_W'(s1_desc_reg.base)),
        .width       (DIM_W'(s1_desc_reg.width)),
        .height      (DIM_W'(s1_desc_reg.height)),
        .x           (s1_x_reg),
        .y           (s1_y_reg),
        .hit         (calc_hit),
        .addr        (calc_addr)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_reg          <= '0;
            s1_valid_reg       <= 1'b0;
            s1_entry_valid_reg <= 1'b0;
            rs_valid_reg       <= 1'b0;
            rs_hit_reg         <= 1'b0;
            rs_addr_reg        <= '0;
            rs_id_reg          <= '0;
            miss_cnt_reg       <= '0;
        end else begin
            valid_reg <= valid_next;
            if (!stall) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_entry_valid_reg <= valid_reg[rq_id];
                end
                rs_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    rs_hit_reg  <= calc_hit;
                    rs_addr_reg <= calc_addr;
                    rs_id_reg   <= s1_id_reg;
                end
            end
            if (rs_valid_reg && rs_ready && !rs_hit_reg && (miss_cnt_reg != 16'hFFFF)) begin
                miss_cnt_reg <= miss_cnt_reg + 16'd1;
            end
        end
    end

    assign rs_valid = rs_valid_reg;
    assign rs_hit   = rs_hit_reg;
    assign rs_addr  = rs_addr_reg;
    assign rs_id    = rs_id_reg;
    assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_sprite_desc_table.sv
// Bench for sprite_desc_table: directed scenarios with literal expectations and a
// randomized phase, all cross-checked every cycle against a behavioural table model.
module tb_sprite_desc_table;

    localparam int ID_W   = 6;
    localparam int ADDR_W = 25;
    localparam int DIM_W  = 10;
    localparam int DEPTH  = 64;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              clr = 1'b0;
    logic              wr_en = 1'b0;
    logic [ID_W-1:0]   wr_id = '0;
    logic [ADDR_W-1:0] wr_base = '0;
    logic [DIM_W-1:0]  wr_width = '0;
    logic [DIM_W-1:0]  wr_height = '0;
    logic              rq_valid = 1'b0;
    logic              rq_ready;
    logic [ID_W-1:0]   rq_id = '0;
    logic [DIM_W-1:0]  rq_x = '0;
    logic [DIM_W-1:0]  rq_y = '0;
    logic              rs_valid;
    logic              rs_ready = 1'b1;
    logic [ADDR_W-1:0] rs_addr;
    logic              rs_hit;
    logic [ID_W-1:0]   rs_id;
    logic [15:0]       miss_cnt;

    sprite_desc_table #(
        .ID_W   (ID_W),
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_id     (wr_id),
        .wr_base   (wr_base),
        .wr_width  (wr_width),
        .wr_height (wr_height),
        .rq_valid  (rq_valid),
        .rq_ready  (rq_ready),
        .rq_id     (rq_id),
        .rq_x      (rq_x),
        .rq_y      (rq_y),
        .rs_valid  (rs_valid),
        .rs_ready  (rs_ready),
        .rs_addr   (rs_addr),
        .rs_hit    (rs_hit),
        .rs_id     (rs_id),
        .miss_cnt  (miss_cnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
        end
    endtask

    // Behavioural model: the table contents and an ordered list of pending responses.
    typedef struct {
        logic              hit;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        int                age;
    } resp_t;

    resp_t             exp_q[$];
    bit                m_valid [DEPTH];
    logic [ADDR_W-1:0] m_base  [DEPTH];
    int                m_w     [DEPTH];
    int                m_h     [DEPTH];
    int                m_miss = 0;

    function automatic resp_t lookup(input int id, input int x, input int y);
        resp_t       r;
        logic [63:0] a;
        r.id  = ID_W'(id);
        r.age = 0;
        r.hit = m_valid[id] && (x < m_w[id]) && (y < m_h[id]);
        a     = 64'(m_base[id]) + 64'(y * m_w[id]) + 64'(x);
        r.addr = r.hit ? a[ADDR_W-1:0] : '0;
        return r;
    endfunction

    // Compare at the falling edge, then advance the model across the next rising edge.
    always @(negedge Clk) begin : model
        logic ev;
        logic st;
        if (!Reset_n) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_miss = 0;
            check("rst_rs_valid", rs_valid, 0);
            check("rst_miss_cnt", miss_cnt, 0);
        end else begin
            ev = (exp_q.size() > 0) && (exp_q[0].age >= 2);
            st = ev && !rs_ready;
            check("rs_valid", rs_valid, ev);
            check("rq_ready", rq_ready, !st);
            check("miss_cnt", miss_cnt, m_miss);
            if (ev) begin
                check("rs_hit", rs_hit, exp_q[0].hit);
                check("rs_addr", rs_addr, exp_q[0].addr);
                check("rs_id", rs_id, exp_q[0].id);
                if (rs_ready) begin
                    if (!exp_q[0].hit && m_miss < 65535) m_miss++;
                    void'(exp_q.pop_front());
                end
            end
            if (rq_valid && !st) exp_q.push_back(lookup(int'(rq_id), int'(rq_x), int'(rq_y)));
            if (!st) begin
                for (int i = 0; i < exp_q.size(); i++) exp_q[i].age++;
            end
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end else if (wr_en) begin
                m_valid[wr_id] = 1'b1;
                m_base[wr_id]  = wr_base;
                m_w[wr_id]     = int'(wr_width);
                m_h[wr_id]     = int'(wr_height);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_desc(input int id, input int base, input int w, input int h);
        wr_en = 1'b1;
        wr_id = ID_W'(id);
        wr_base = ADDR_W'(base);
        wr_width = DIM_W'(w);
        wr_height = DIM_W'(h);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic single_req(input int id, input int x, input int y,
                              output logic hit, output logic [ADDR_W-1:0] addr, output int lat);
        check("idle_rq_ready", rq_ready, 1);
        rq_valid = 1'b1;
        rq_id = ID_W'(id);
        rq_x = DIM_W'(x);
        rq_y = DIM_W'(y);
        tick();
        rq_valid = 1'b0;
        wr_en = 1'b0;
        clr = 1'b0;
        lat = 1;
        while (!rs_valid && lat < 20) begin
            tick();
            lat++;
        end
        hit = rs_hit;
        addr = rs_addr;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              hit;
        logic [ADDR_W-1:0] addr;
        int                lat;
        logic [ADDR_W-1:0] held_addr;
        logic              held_hit;
        logic [ID_W-1:0]   held_id;

        repeat (3) tick();
        check("reset_rs_valid", rs_valid, 0);
        check("reset_rs_hit", rs_hit, 0);
        check("reset_rs_addr", rs_addr, 0);
        check("reset_rs_id", rs_id, 0);
        check("reset_miss_cnt", miss_cnt, 0);
        Reset_n = 1'b1;
        tick();
        check("ready_after_reset", rq_ready, 1);

        // Basic hit: 320646 + 2*99 + 10
        write_desc(3, 320646, 99, 66);
        single_req(3, 10, 2, hit, addr, lat);
        check("hit_basic", hit, 1);
        check("addr_basic", addr, 320854);
        check("latency_basic", lat, 2);

        // x equal to width is out of bounds; unwritten id misses
        single_req(3, 99, 0, hit, addr, lat);
        check("hit_x_edge", hit, 0);
        check("addr_x_edge", addr, 0);
        check("miss_after_edge", miss_cnt, 1);
        single_req(7, 0, 0, hit, addr, lat);
        check("hit_unwritten", hit, 0);
        check("miss_after_unwritten", miss_cnt, 2);

        // Back-to-back requests with rs_ready low for three cycles
        for (int i = 0; i < 12; i++) begin
            rq_valid = 1'b1;
            rq_id = ID_W'($urandom_range(0, 7));
            rq_x = DIM_W'($urandom_range(0, 20));
            rq_y = DIM_W'($urandom_range(0, 20));
            rs_ready = !(i >= 4 && i <= 6);
            #1;
            if (i >= 4 && i <= 6) check("stall_rq_ready", rq_ready, 0);
            if (i == 4) begin
                held_addr = rs_addr;
                held_hit = rs_hit;
                held_id = rs_id;
            end else if (i == 5 || i == 6) begin
                check("held_addr", rs_addr, held_addr);
                check("held_hit", rs_hit, held_hit);
                check("held_id", rs_id, held_id);
            end
            tick();
        end
        rq_valid = 1'b0;
        rs_ready = 1'b1;
        repeat (4) tick();

        // Write to id 3 in the same cycle it is looked up
        wr_en = 1'b1;
        wr_id = 3;
        wr_base = '0;
        wr_width = 99;
        wr_height = 66;
        single_req(3, 10, 2, hit, addr, lat);
        check("rbw_old_base", addr, 320854);
        check("rbw_old_hit", hit, 1);
        single_req(3, 10, 2, hit, addr, lat);
        check("rbw_new_base", addr, 208);

        // clr wins over a simultaneous write
        write_desc(5, 1000, 8, 8);
        single_req(5, 1, 1, hit, addr, lat);
        check("id5_before_clr", addr, 1009);
        clr = 1'b1;
        wr_en = 1'b1;
        wr_id = 5;
        tick();
        clr = 1'b0;
        wr_en = 1'b0;
        single_req(5, 1, 1, hit, addr, lat);
        check("id5_after_clr", hit, 0);
        single_req(3, 10, 2, hit, addr, lat);
        check("id3_after_clr", hit, 0);

        // Reset pulse in the middle of a miss stream
        for (int i = 0; i < 6; i++) begin
            rq_valid = 1'b1;
            rq_id = 7;
            rq_x = 0;
            rq_y = 0;
            tick();
        end
        check("pre_reset_miss_nonzero", miss_cnt != 16'd0, 1);
        #2;
        rq_valid = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("midrst_rs_valid", rs_valid, 0);
        check("midrst_miss_cnt", miss_cnt, 0);
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        check("midrst_rq_ready", rq_ready, 1);
        tick();

        // Address wrap at ADDR_W bits
        write_desc(9, 33554400, 64, 4);
        single_req(9, 0, 1, hit, addr, lat);
        check("wrap_hit", hit, 1);
        check("wrap_addr", addr, 32);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rq_valid = ($urandom_range(0, 3) != 0);
            rq_id = ID_W'($urandom_range(0, 7));
            rq_x = DIM_W'($urandom_range(0, 110));
            rq_y = DIM_W'($urandom_range(0, 110));
            rs_ready = ($urandom_range(0, 3) != 0);
            wr_en = ($urandom_range(0, 7) == 0);
            wr_id = ID_W'($urandom_range(0, 7));
            wr_base = ADDR_W'($urandom);
            wr_width = DIM_W'($urandom_range(1, 100));
            wr_height = DIM_W'($urandom_range(1, 100));
            clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        rq_valid = 1'b0;
        wr_en = 1'b0;
        clr = 1'b0;
        rs_ready = 1'b1;
        repeat (4) tick();

        // Miss counter saturation
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        rq_valid = 1'b1;
        rq_id = 7;
        rq_x = 0;
        rq_y = 0;
        repeat (65540) tick();
        rq_valid = 1'b0;
        repeat (4) tick();
        check("miss_saturate", miss_cnt, 65535);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
